// File: rtl/s2mm_launch_master.sv
// AXI4-Lite initiator: programs an S2MM kernel, starts it,
// polls ap_done and returns the captured TID as a status beat.
module s2mm_launch_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int POLL_GAP           = 16,
  parameter int MAX_POLLS          = 0
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [63:0]                     cmd_mem,
  input  logic [31:0]                     cmd_size,
  input  logic [7:0]                      cmd_tdest,
  output logic                            sts_valid,
  input  logic                            sts_ready,
  output logic [7:0]                      sts_tid,
  output logic                            sts_tid_vld,
  output logic [1:0]                      sts_err,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_POLL_WAIT,
    S_RD_CTRL,
    S_RD_TIDC,
    S_RD_TID,
    S_STS
  } state_t;

  localparam logic [15:0] GAP_LOAD =
    (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

  state_t      state;
  state_t      state_nx;
  state_t      poll_dest;

  logic [63:0] mem_q;
  logic [31:0] size_q;
  logic [7:0]  tdest_q;
  logic [2:0]  widx;
  logic        aw_pend;
  logic        w_pend;
  logic        ar_pend;
  logic [15:0] gap_cnt;
  logic [15:0] poll_cnt;
  logic [16:0] poll_nx;

  logic [5:0]  wr_off;
  logic [31:0] wr_data;
  logic [5:0]  rd_off;

  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic b_err;
  logic r_err;
  logic rd_state;
  logic rd_nx;
  logic last_wr;
  logic poll_limit;
  logic done_bit;
  logic unused_rdata;

  assign cmd_hs   = cmd_valid & cmd_ready;
  assign aw_hs    = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs     = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs     = M_AXI_BVALID & M_AXI_BREADY;
  assign ar_hs    = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs     = M_AXI_RVALID & M_AXI_RREADY;
  assign b_err    = |M_AXI_BRESP;
  assign r_err    = |M_AXI_RRESP;
  assign done_bit = M_AXI_RDATA[1];
  assign last_wr  = (widx == 3'd4);

  assign unused_rdata = ^M_AXI_RDATA[C_M_AXI_DATA_WIDTH-1:8];

  assign rd_state = (state == S_RD_CTRL) | (state == S_RD_TIDC) |
                    (state == S_RD_TID);
  assign rd_nx    = (state_nx == S_RD_CTRL) | (state_nx == S_RD_TIDC) |
                    (state_nx == S_RD_TID);

  assign poll_nx    = {1'b0, poll_cnt} + 17'd1;
  assign poll_limit = (MAX_POLLS != 0) && (poll_nx >= 17'(MAX_POLLS));
  assign poll_dest  = (POLL_GAP == 0) ? S_RD_CTRL : S_POLL_WAIT;

  always_comb begin
    wr_off  = 6'h00;
    wr_data = 32'h0;
    case (widx)
      3'd0: begin wr_off = 6'h10; wr_data = mem_q[31:0]; end
      3'd1: begin wr_off = 6'h14; wr_data = mem_q[63:32]; end
      3'd2: begin wr_off = 6'h1C; wr_data = size_q; end
      3'd3: begin wr_off = 6'h2C; wr_data = {24'h0, tdest_q}; end
      default: begin wr_off = 6'h00; wr_data = 32'h1; end
    endcase
  end

  always_comb begin
    rd_off = 6'h00;
    unique case (1'b1)
      state == S_RD_TIDC: rd_off = 6'h28;
      state == S_RD_TID:  rd_off = 6'h24;
      default:            rd_off = 6'h00;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (cmd_valid) state_nx = S_WR;
      S_WR:
        if ((!aw_pend || aw_hs) && (!w_pend || w_hs))
          state_nx = S_WR_RESP;
      S_WR_RESP:
        if (b_hs) begin
          if (b_err)        state_nx = S_STS;
          else if (last_wr) state_nx = poll_dest;
          else              state_nx = S_WR;
        end
      S_POLL_WAIT:
        if (gap_cnt == 16'd0) state_nx = S_RD_CTRL;
      S_RD_CTRL:
        if (r_hs) begin
          if (r_err)           state_nx = S_STS;
          else if (done_bit)   state_nx = S_RD_TIDC;
          else if (poll_limit) state_nx = S_STS;
          else                 state_nx = poll_dest;
        end
      S_RD_TIDC:
        if (r_hs) state_nx = r_err ? S_STS : S_RD_TID;
      S_RD_TID:
        if (r_hs) state_nx = S_STS;
      S_STS:
        if (sts_ready) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      mem_q       <= '0;
      size_q      <= '0;
      tdest_q     <= '0;
      widx        <= '0;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      ar_pend     <= 1'b0;
      gap_cnt     <= '0;
      poll_cnt    <= '0;
      sts_err     <= '0;
      sts_tid     <= '0;
      sts_tid_vld <= 1'b0;
    end else begin
      if (cmd_hs) begin
        mem_q       <= cmd_mem;
        size_q      <= cmd_size;
        tdest_q     <= cmd_tdest;
        widx        <= '0;
        poll_cnt    <= '0;
        sts_err     <= '0;
        sts_tid     <= '0;
        sts_tid_vld <= 1'b0;
      end
      if (aw_hs) aw_pend <= 1'b0;
      if (w_hs)  w_pend  <= 1'b0;
      if (state_nx == S_WR && state != S_WR) begin
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end
      if (b_hs) widx <= widx + 3'd1;
      if (state_nx == S_POLL_WAIT && state != S_POLL_WAIT)
        gap_cnt <= GAP_LOAD;
      else if (state == S_POLL_WAIT)
        gap_cnt <= gap_cnt - 16'd1;
      if (ar_hs) ar_pend <= 1'b0;
      if (rd_nx && (!rd_state || r_hs)) ar_pend <= 1'b1;
      if (r_hs && state == S_RD_CTRL && !(&poll_cnt))
        poll_cnt <= poll_cnt + 16'd1;
      if (r_hs && !r_err && state == S_RD_TIDC)
        sts_tid_vld <= M_AXI_RDATA[0];
      if (r_hs && !r_err && state == S_RD_TID)
        sts_tid <= M_AXI_RDATA[7:0];
      if (r_hs && !r_err && state == S_RD_CTRL &&
          !done_bit && poll_limit)
        sts_err <= 2'd2;
      // An error response voids anything captured so far.
      if ((b_hs && b_err) || (r_hs && r_err)) begin
        sts_err     <= 2'd1;
        sts_tid     <= '0;
        sts_tid_vld <= 1'b0;
      end
    end
  end

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign sts_valid     = (state == S_STS);
  assign M_AXI_AWVALID = (state == S_WR) & aw_pend;
  assign M_AXI_WVALID  = (state == S_WR) & w_pend;
  assign M_AXI_BREADY  = (state == S_WR_RESP);
  assign M_AXI_ARVALID = rd_state & ar_pend;
  assign M_AXI_RREADY  = rd_state;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWADDR  = (state == S_WR) ?
                         C_M_AXI_ADDR_WIDTH'(wr_off) : '0;
  assign M_AXI_WDATA   = (state == S_WR) ?
                         C_M_AXI_DATA_WIDTH'(wr_data) : '0;
  assign M_AXI_ARADDR  = rd_state ?
                         C_M_AXI_ADDR_WIDTH'(rd_off) : '0;

endmodule

// File: tb/tb_s2mm_launch_master.sv
// Bench for s2mm_launch_master: AXI4-Lite slave model,
// transaction-level expectation model and per-cycle checker.
module tb_s2mm_launch_master;

  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int GAP  = 5;
  localparam int MAXP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [63:0]   cmd_mem;
  logic [31:0]   cmd_size;
  logic [7:0]    cmd_tdest;
  logic          sts_valid, sts_ready;
  logic [7:0]    sts_tid;
  logic          sts_tid_vld;
  logic [1:0]    sts_err;
  logic          busy;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  s2mm_launch_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .POLL_GAP(GAP),
    .MAX_POLLS(MAXP)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mem(cmd_mem), .cmd_size(cmd_size), .cmd_tdest(cmd_tdest),
    .sts_valid(sts_valid), .sts_ready(sts_ready),
    .sts_tid(sts_tid), .sts_tid_vld(sts_tid_vld), .sts_err(sts_err),
    .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // slave configuration and observed state
  int          aw_lat, w_lat, b_lat, ar_lat, done_on, werr, rerr;
  logic [7:0]  tid_cfg;
  logic        vld_cfg;
  logic [31:0] regs [0:63];
  int          polls, nwr;

  // expectation model
  logic [5:0]  exp_wa [0:4];
  logic [31:0] exp_wd [0:4];
  logic [5:0]  exp_ra [0:7];
  int          n_w, n_r;
  logic [1:0]  exp_err;
  logic [7:0]  exp_tid;
  logic        exp_vld;
  int          aw_i, w_i, ar_i, sts_seen;
  logic [1:0]  got_err;
  logic [7:0]  got_tid;
  logic        got_vld;

  function automatic logic [31:0] rd_val(input logic [5:0] a);
    logic [31:0] v;
    v = regs[a];
    if (a == 6'h00) begin
      polls++;
      v = (done_on != 0 && polls == done_on) ? 32'h2 : 32'h0;
    end else if (a == 6'h28) begin
      v = {31'h0, vld_cfg};
    end else if (a == 6'h24) begin
      v = {24'h0, tid_cfg};
    end
    return v;
  endfunction

  initial begin : slave
    logic aw_h, w_h, b_h, ar_h, r_h, rs;
    logic [5:0] sa_aw, sa_ar, wa;
    logic [31:0] sd_w, wd;
    logic got_aw, got_w, b_pend;
    int aw_wt, w_wt, b_wt, ar_wt;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    got_aw = 0; got_w = 0; b_pend = 0;
    aw_wt = 0; w_wt = 0; b_wt = 0; ar_wt = 0;
    wa = 0; wd = 0;
    forever begin
      @(negedge clk);
      rs = rst_n;
      aw_h = awvalid && awready; sa_aw = awaddr;
      w_h = wvalid && wready;    sd_w = wdata;
      b_h = bvalid && bready;
      ar_h = arvalid && arready; sa_ar = araddr;
      r_h = rvalid && rready;
      @(posedge clk); #1;
      if (!rs) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0;
        got_aw = 0; got_w = 0; b_pend = 0;
        aw_wt = 0; w_wt = 0; b_wt = 0; ar_wt = 0;
        continue;
      end
      if (b_h) begin
        bvalid = 0; b_pend = 0; got_aw = 0; got_w = 0;
      end
      if (aw_h) begin got_aw = 1; wa = sa_aw; aw_wt = 0; end
      if (w_h)  begin got_w = 1;  wd = sd_w;  w_wt = 0;  end
      if (got_aw && got_w && !b_pend && !b_h) begin
        regs[wa] = wd; nwr++; b_pend = 1; b_wt = 0;
      end
      if (b_pend && !bvalid) begin
        if (b_wt >= b_lat) begin
          bvalid = 1;
          bresp = (int'(wa) == werr) ? 2'b10 : 2'b00;
        end else b_wt++;
      end
      awready = 0;
      if (awvalid && !got_aw) begin
        if (aw_wt >= aw_lat) awready = 1; else aw_wt++;
      end
      wready = 0;
      if (wvalid && !got_w) begin
        if (w_wt >= w_lat) wready = 1; else w_wt++;
      end
      if (r_h) rvalid = 0;
      if (ar_h) begin
        rvalid = 1;
        rdata = rd_val(sa_ar);
        rresp = (int'(sa_ar) == rerr) ? 2'b10 : 2'b00;
        ar_wt = 0;
      end
      arready = 0;
      if (arvalid) begin
        if (ar_wt >= ar_lat) arready = 1; else ar_wt++;
      end
    end
  end

  // per-cycle checker against the expectation model
  initial begin : cmp
    int s, last;
    logic in_fl, p_aw, p_w, p_ar, p_sts, p_awr, p_wr, p_arr;
    logic [5:0] p_awa, p_ara;
    logic [31:0] p_wd;
    s = 0; last = 0; in_fl = 0;
    p_aw = 0; p_w = 0; p_ar = 0; p_sts = 0;
    p_awr = 0; p_wr = 0; p_arr = 0;
    p_awa = 0; p_ara = 0; p_wd = 0;
    forever begin
      @(negedge clk);
      s++;
      if (!rst_n) begin
        in_fl = 0; p_aw = 0; p_w = 0; p_ar = 0; p_sts = 0;
        continue;
      end
      check("busy", busy, in_fl);
      check("cmd_ready", cmd_ready, !in_fl);
      if (p_aw && !p_awr) begin
        check("awvalid_hold", awvalid, 1'b1);
        check("awaddr_hold", awaddr, p_awa);
      end
      if (p_w && !p_wr) begin
        check("wvalid_hold", wvalid, 1'b1);
        check("wdata_hold", wdata, p_wd);
      end
      if (p_ar && !p_arr) begin
        check("arvalid_hold", arvalid, 1'b1);
        check("araddr_hold", araddr, p_ara);
      end
      if (awvalid && !p_aw) begin
        check("aw_latency", s - last, 1);
        check("w_with_aw", wvalid, 1'b1);
      end
      if (arvalid && !p_ar)
        check("ar_latency", s - last, (araddr == 0) ? GAP + 1 : 1);
      if (sts_valid && !p_sts) check("sts_latency", s - last, 1);
      if (sts_valid) begin
        sts_seen++;
        check("sts_err", sts_err, exp_err);
        check("sts_tid", sts_tid, exp_tid);
        check("sts_tid_vld", sts_tid_vld, exp_vld);
        got_err = sts_err; got_tid = sts_tid; got_vld = sts_tid_vld;
      end
      if (awvalid && awready) begin
        if (aw_i < n_w) check("awaddr", awaddr, exp_wa[aw_i]);
        else check("aw_extra", aw_i + 1, n_w);
        aw_i++;
      end
      if (wvalid && wready) begin
        if (w_i < n_w) check("wdata", wdata, exp_wd[w_i]);
        else check("w_extra", w_i + 1, n_w);
        check("wstrb", wstrb, 4'hF);
        w_i++;
      end
      if (arvalid && arready) begin
        if (ar_i < n_r) check("araddr", araddr, exp_ra[ar_i]);
        else check("ar_extra", ar_i + 1, n_r);
        ar_i++;
      end
      if (cmd_valid && cmd_ready) begin in_fl = 1; last = s; end
      if (bvalid && bready) last = s;
      if (rvalid && rready) last = s;
      if (sts_valid && sts_ready) in_fl = 0;
      p_aw = awvalid; p_awr = awready; p_awa = awaddr;
      p_w = wvalid;   p_wr = wready;   p_wd = wdata;
      p_ar = arvalid; p_arr = arready; p_ara = araddr;
      p_sts = sts_valid;
    end
  end

  task automatic build(input logic [63:0] mem, input logic [31:0] size,
                       input logic [7:0] td);
    logic [5:0] offs [0:4];
    int np;
    offs = '{6'h10, 6'h14, 6'h1C, 6'h2C, 6'h00};
    exp_wd = '{mem[31:0], mem[63:32], size, {24'h0, td}, 32'h1};
    exp_wa = offs;
    n_w = 0; n_r = 0; exp_err = 0; exp_tid = 0; exp_vld = 0;
    for (int k = 0; k < 5; k++) begin
      n_w++;
      if (int'(offs[k]) == werr) begin exp_err = 1; return; end
    end
    np = (done_on != 0 && done_on <= MAXP) ? done_on : MAXP;
    for (int p = 0; p < np; p++) begin
      exp_ra[n_r] = 6'h00; n_r++;
      if (rerr == 0) begin exp_err = 1; return; end
    end
    if (done_on == 0 || done_on > MAXP) begin exp_err = 2; return; end
    exp_ra[n_r] = 6'h28; n_r++;
    if (rerr == 'h28) begin exp_err = 1; return; end
    exp_ra[n_r] = 6'h24; n_r++;
    if (rerr == 'h24) begin exp_err = 1; return; end
    exp_tid = tid_cfg; exp_vld = vld_cfg;
  endtask

  task automatic set_lat(input int a, input int w, input int b,
                         input int r);
    aw_lat = a; w_lat = w; b_lat = b; ar_lat = r;
  endtask

  task automatic run(input logic [63:0] mem, input logic [31:0] size,
                     input logic [7:0] td, input int don,
                     input logic [7:0] tid, input logic vld,
                     input int we, input int re, input int hold);
    int t;
    done_on = don; tid_cfg = tid; vld_cfg = vld; werr = we; rerr = re;
    polls = 0; nwr = 0;
    foreach (regs[i]) regs[i] = '0;
    build(mem, size, td);
    aw_i = 0; w_i = 0; ar_i = 0; sts_seen = 0;
    cmd_mem = mem; cmd_size = size; cmd_tdest = td; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    sts_ready = (hold == 0);
    t = 0;
    while (!sts_valid && t < 500) begin @(posedge clk); #1; t++; end
    if (!sts_valid) check("sts_wait_timeout", t, 0);
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      sts_ready = 1;
    end
    @(posedge clk); #1;
    sts_ready = 0;
    check("n_aw", aw_i, n_w);
    check("n_w", w_i, n_w);
    check("n_ar", ar_i, n_r);
    check("sts_cycles", sts_seen, hold + 1);
  endtask

  task automatic pin_nominal(input string tag);
    check({tag, "_reg10"}, regs[6'h10], 32'h8000_0000);
    check({tag, "_reg14"}, regs[6'h14], 32'h0000_0008);
    check({tag, "_reg1c"}, regs[6'h1C], 32'h0000_1000);
    check({tag, "_reg2c"}, regs[6'h2C], 32'h0000_0003);
    check({tag, "_reg00"}, regs[6'h00], 32'h0000_0001);
    check({tag, "_nwr"}, nwr, 5);
    check({tag, "_polls"}, polls, 3);
    check({tag, "_tid"}, got_tid, 8'h5A);
    check({tag, "_vld"}, got_vld, 1'b1);
    check({tag, "_err"}, got_err, 2'd0);
  endtask

  localparam logic [63:0] NOM_MEM = 64'h0000_0008_8000_0000;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    cmd_valid = 0; cmd_mem = 0; cmd_size = 0; cmd_tdest = 0;
    sts_ready = 0;
    set_lat(0, 0, 0, 0);
    done_on = 0; werr = -1; rerr = -1; tid_cfg = 0; vld_cfg = 0;
    n_w = 0; n_r = 0; exp_err = 0; exp_tid = 0; exp_vld = 0;
    aw_i = 0; w_i = 0; ar_i = 0; sts_seen = 0;
    got_err = 0; got_tid = 0; got_vld = 0;
    polls = 0; nwr = 0;
    foreach (regs[i]) regs[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_sts_valid", sts_valid, 1'b0);
    check("rst_sts_err", sts_err, 2'd0);
    check("rst_sts_tid", sts_tid, 8'd0);
    check("rst_sts_tid_vld", sts_tid_vld, 1'b0);
    check("rst_awaddr", awaddr, 6'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_araddr", araddr, 6'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rel_cmd_ready", cmd_ready, 1'b1);
    check("rel_busy", busy, 1'b0);

    // nominal launch
    set_lat(0, 0, 0, 0);
    run(NOM_MEM, 32'd4096, 8'd3, 3, 8'h5A, 1'b1, -1, -1, 0);
    pin_nominal("nom");

    // AW accepted before W, slow B
    set_lat(0, 3, 5, 0);
    run(NOM_MEM, 32'd4096, 8'd3, 3, 8'h5A, 1'b1, -1, -1, 0);
    pin_nominal("skew_aw");

    // W accepted before AW, slow B and AR
    set_lat(3, 0, 5, 2);
    run(NOM_MEM, 32'd4096, 8'd3, 3, 8'h5A, 1'b1, -1, -1, 0);
    pin_nominal("skew_w");

    // BRESP error on the size write
    set_lat(0, 0, 0, 0);
    run(64'h1234_5678_9ABC_DEF0, 32'h20, 8'h7, 3, 8'h11, 1'b1,
        'h1C, -1, 0);
    check("werr_nwr", nwr, 3);
    check("werr_reg2c", regs[6'h2C], 32'h0);
    check("werr_reg00", regs[6'h00], 32'h0);
    check("werr_polls", polls, 0);
    check("werr_err", got_err, 2'd1);

    // ap_done never set
    run(NOM_MEM, 32'd4096, 8'd3, 0, 8'h5A, 1'b1, -1, -1, 0);
    check("tmo_polls", polls, 4);
    check("tmo_err", got_err, 2'd2);
    check("tmo_vld", got_vld, 1'b0);
    check("tmo_tid", got_tid, 8'h00);

    // done exactly on the last allowed poll
    run(64'hFFFF_FFFF_0000_0040, 32'd1, 8'hFF, 4, 8'hA5, 1'b0,
        -1, -1, 0);
    check("edge_polls", polls, 4);
    check("edge_err", got_err, 2'd0);
    check("edge_tid", got_tid, 8'hA5);
    check("edge_reg2c", regs[6'h2C], 32'h0000_00FF);

    // RRESP error on the TID ap_vld read
    run(NOM_MEM, 32'd64, 8'd9, 1, 8'h33, 1'b1, -1, 'h28, 0);
    check("rerr_err", got_err, 2'd1);
    check("rerr_tid", got_tid, 8'h00);
    check("rerr_polls", polls, 1);

    // status backpressure
    run(NOM_MEM, 32'd4096, 8'd3, 3, 8'h5A, 1'b1, -1, -1, 10);
    pin_nominal("bp");

    // reset in the middle of a write
    set_lat(8, 8, 0, 0);
    done_on = 3; werr = -1; rerr = -1;
    build(NOM_MEM, 32'd4096, 8'd3);
    aw_i = 0; w_i = 0; ar_i = 0; sts_seen = 0;
    cmd_mem = NOM_MEM; cmd_size = 32'd4096; cmd_tdest = 8'd3;
    cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    t = 0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid_awvalid", awvalid, 1'b1);
    rst_n = 0;
    @(posedge clk); #1;
    check("arst_awvalid", awvalid, 1'b0);
    check("arst_wvalid", wvalid, 1'b0);
    check("arst_bready", bready, 1'b0);
    check("arst_arvalid", arvalid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_awaddr", awaddr, 6'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("arst_cmd_ready", cmd_ready, 1'b1);
    check("arst_sts_valid", sts_valid, 1'b0);

    // launch again after the abort
    set_lat(0, 0, 0, 0);
    run(NOM_MEM, 32'd4096, 8'd3, 3, 8'h5A, 1'b1, -1, -1, 0);
    pin_nominal("again");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
